// File: rtl/regularization_pkg.sv
// Shared helpers for the regularization block.
// Holds only a width-sizing function; all tunable constants stay module parameters.
package regularization_pkg;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int unsigned ctr_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : regularization_pkg

// File: rtl/regularization_lane.sv
// One-bit debounce-and-hold-off lane.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-low reset
//   i_signal - raw input bit, sampled every edge
//   o_signal - regularized bit, straight from a flop
// A change is accepted after DEBOUNCE_TIME consecutive differing samples; the
// output is then frozen for DELAY edges before counting may start again.
module regularization_lane
   import regularization_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TIME = 2,
   parameter int unsigned DELAY         = 100
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_signal,
   output logic o_signal
);

   localparam int unsigned CNT_W  = ctr_width(DEBOUNCE_TIME);
   localparam int unsigned HOLD_W = ctr_width(DELAY);

   // Count value at which the next differing sample completes the debounce.
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_TIME - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DELAY);

   logic              out_q,  out_d;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   // Next-state: hold-off has priority, then stability counting.
   // cnt never passes CNT_LAST (it clears on acceptance) and hold only
   // decrements while nonzero, so neither counter can wrap.
   always_comb begin
      out_d  = out_q;
      cnt_d  = cnt_q;
      hold_d = hold_q;
      if (hold_q != '0) begin
         hold_d = hold_q - HOLD_W'(1);
         cnt_d  = '0;
      end else if (i_signal == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         out_d  = i_signal;
         cnt_d  = '0;
         hold_d = HOLD_LOAD;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Lane state registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         out_q  <= 1'b0;
         cnt_q  <= '0;
         hold_q <= '0;
      end else begin
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
      end
   end

   assign o_signal = out_q;

endmodule : regularization_lane

// File: rtl/regularization.sv
// N independent debounce/hold-off lanes for sign or condition bits.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-low reset
//   i_signal - N raw bits, sampled every edge
//   o_signal - N regularized bits, each driven from a lane flop
module regularization #(
   parameter int unsigned DEBOUNCE_TIME = 2,
   parameter int unsigned DELAY         = 100,
   parameter int unsigned N             = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [N-1:0] i_signal,
   output logic [N-1:0] o_signal
);

   // Lanes share nothing but clock and reset.
   for (genvar g = 0; g < int'(N); g++) begin : g_lane
      regularization_lane #(
         .DEBOUNCE_TIME (DEBOUNCE_TIME),
         .DELAY         (DELAY)
      ) u_lane (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_signal (i_signal[g]),
         .o_signal (o_signal[g])
      );
   end

endmodule : regularization

// File: tb/tb_regularization.sv
// Self-checking bench for regularization: default instance (N=2, DEBOUNCE_TIME=2,
// DELAY=100) plus a fast instance (DEBOUNCE_TIME=1, DELAY=0).
module tb_regularization;

   logic       i_clk;
   logic       i_reset;
   logic [1:0] i_signal;
   logic [1:0] o_signal;
   logic [1:0] i_signal_f;
   logic [1:0] o_signal_f;

   int checks;
   int failures;

   logic [1:0] exp_q[$];

   regularization #(
      .DEBOUNCE_TIME (2),
      .DELAY         (100),
      .N             (2)
   ) u_dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_signal (i_signal),
      .o_signal (o_signal)
   );

   regularization #(
      .DEBOUNCE_TIME (1),
      .DELAY         (0),
      .N             (2)
   ) u_fast (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_signal (i_signal_f),
      .o_signal (o_signal_f)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Reset behaviour: async clear, idle after release, abort of a debounce in progress.
   task automatic test_reset;
      logic [1:0] got, exp;
      i_reset  = 1'b0;
      i_signal = 2'b11;
      #1;
      checks++;
      if (o_signal !== 2'b00) begin
         failures++;
         $display("FAIL reset_async got=%b exp=00", o_signal);
      end
      // Edges while held in reset must not move anything.
      for (int j = 0; j < 3; j++) begin
         exp_q.push_back(2'b00);
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_held edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
      i_signal = 2'b00;
      i_reset  = 1'b1;
      for (int j = 0; j < 10; j++) begin
         exp_q.push_back(2'b00);
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_idle edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
      // One differing edge, then reset: the partial count must be discarded.
      i_signal = 2'b01;
      exp_q.push_back(2'b00);
      @(posedge i_clk); #1;
      got = o_signal; exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset_prearm got=%b exp=%b", got, exp);
      end
      i_reset = 1'b0;
      #2;
      i_reset = 1'b1;
      for (int j = 0; j < 3; j++) begin
         exp_q.push_back((j == 0) ? 2'b00 : 2'b01);
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_abort_debounce edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
   endtask

   // Debounce latency and hold-off window on a single lane.
   task automatic test_debounce_holdoff;
      logic [1:0] got, exp, v;
      i_signal = 2'b00;
      i_reset  = 1'b0;
      #2;
      i_reset  = 1'b1;
      // j=0 is edge k; change accepted at k+1, revert held from k+2, accepted at k+103.
      for (int j = 0; j <= 106; j++) begin
         v = (j < 2) ? 2'b01 : 2'b00;
         exp_q.push_back((j >= 1 && j < 103) ? 2'b01 : 2'b00);
         i_signal = v;
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL holdoff edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
   endtask

   // Glitch shorter than the debounce time is filtered; two edges pass.
   task automatic test_glitch;
      logic [1:0] got, exp, v;
      i_signal = 2'b00;
      i_reset  = 1'b0;
      #2;
      i_reset  = 1'b1;
      for (int j = 0; j < 12; j++) begin
         v = (j == 1 || j == 6 || j >= 7) ? 2'b10 : 2'b00;
         exp_q.push_back((j >= 7) ? 2'b10 : 2'b00);
         i_signal = v;
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL glitch edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
   endtask

   // Both lanes change together; afterwards bit0 chatters without affecting bit1.
   task automatic test_simultaneous;
      logic [1:0] got, exp, v;
      i_signal = 2'b00;
      i_reset  = 1'b0;
      #2;
      i_reset  = 1'b1;
      for (int j = 0; j <= 110; j++) begin
         if (j < 2) v = 2'b11;
         else       v = {1'b0, 1'(j % 2)};
         exp = {1'(j >= 1 && j < 103), 1'(j >= 1)};
         exp_q.push_back(exp);
         i_signal = v;
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL simultaneous edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
   endtask

   // Reset in the middle of hold-off clears output and hold-off.
   task automatic test_reset_mid_holdoff;
      logic [1:0] got, exp;
      i_signal = 2'b00;
      i_reset  = 1'b0;
      #2;
      i_reset  = 1'b1;
      // Update at j=1 loads 100; after edge j=51 hold is 50.
      for (int j = 0; j <= 51; j++) begin
         exp_q.push_back((j >= 1) ? 2'b11 : 2'b00);
         i_signal = 2'b11;
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL midhold_setup edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
      i_reset = 1'b0;
      #1;
      checks++;
      if (o_signal !== 2'b00) begin
         failures++;
         $display("FAIL midhold_async got=%b exp=00", o_signal);
      end
      #1;
      i_reset = 1'b1;
      for (int j = 0; j < 4; j++) begin
         exp_q.push_back((j >= 1) ? 2'b11 : 2'b00);
         @(posedge i_clk); #1;
         got = o_signal; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL midhold_recover edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
   endtask

   // DEBOUNCE_TIME=1, DELAY=0: output is the input delayed by one edge.
   task automatic test_fast_follow;
      logic [1:0] got, exp, v;
      i_signal_f = 2'b00;
      i_reset    = 1'b0;
      #2;
      i_reset    = 1'b1;
      for (int j = 0; j < 60; j++) begin
         v = 2'($urandom_range(0, 3));
         exp_q.push_back(v);
         i_signal_f = v;
         @(posedge i_clk); #1;
         got = o_signal_f; exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL fast_follow edge=%0d got=%b exp=%b", j, got, exp);
         end
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      i_reset    = 1'b0;
      i_signal   = 2'b00;
      i_signal_f = 2'b00;
      @(posedge i_clk); #1;
      test_reset();
      test_debounce_holdoff();
      test_glitch();
      test_simultaneous();
      test_reset_mid_holdoff();
      test_fast_follow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regularization
